// File: rtl/rv_mem_bridge.sv
// Memory bridge: posts core stores into a write buffer and serialises
// stores, loads and fetches onto a single req/ack word bus.
module rv_mem_bridge #(
  parameter int DPWIDTH = 32,
  parameter int WBDEPTH = 4,
  localparam int CW = $clog2(WBDEPTH + 1),
  localparam int PW = $clog2(WBDEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ireq,
  input  logic [DPWIDTH-1:0] imem_addr,
  output logic [DPWIDTH-1:0] imem_datain,
  input  logic               dreq,
  input  logic               memrw,
  input  logic [DPWIDTH-1:0] dmem_addr,
  input  logic [DPWIDTH-1:0] dmem_dataout,
  output logic [DPWIDTH-1:0] dmem_datain,
  output logic               stall,
  output logic               bus_req,
  output logic               bus_we,
  output logic [DPWIDTH-1:0] bus_addr,
  output logic [DPWIDTH-1:0] bus_wdata,
  input  logic               bus_ack,
  input  logic [DPWIDTH-1:0] bus_rdata,
  output logic [CW-1:0]      wb_count
);

  typedef enum logic [2:0] {
    IDLE, WR, RD_D, RD_I, RESP_D, RESP_I
  } state_e;

  localparam logic [DPWIDTH-1:0] AMASK = ~DPWIDTH'(3);

  logic [DPWIDTH-1:0] wb_addr_q [WBDEPTH];
  logic [DPWIDTH-1:0] wb_data_q [WBDEPTH];

  state_e             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [DPWIDTH-1:0] addr_q, addr_d;
  logic [DPWIDTH-1:0] wdata_q, wdata_d;
  logic [DPWIDTH-1:0] imem_q, imem_d;
  logic [DPWIDTH-1:0] dmem_q, dmem_d;
  logic               d_done_q, d_done_d;

  logic full, empty, rd_d, push, pop;

  always_comb begin
    full  = (cnt_q == CW'(WBDEPTH));
    empty = (cnt_q == '0);
    rd_d  = dreq & ~memrw;
    push  = dreq & memrw & ~full;
    pop   = (state_q == WR) & bus_ack;
    // d_done marks a load already answered while a fetch is still owed
    stall = rst & ((dreq & memrw & full)
          | (rd_d & ~d_done_q & (state_q != RESP_D))
          | (ireq & (state_q != RESP_I)));
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    imem_d   = imem_q;
    dmem_d   = dmem_q;
    d_done_d = d_done_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = WR;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = wb_addr_q[rd_ptr_q] & AMASK;
          wdata_d = wb_data_q[rd_ptr_q];
        end else if (rd_d && !d_done_q) begin
          state_d = RD_D;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = dmem_addr & AMASK;
        end else if (ireq) begin
          state_d = RD_I;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = imem_addr & AMASK;
        end
      end
      WR: if (bus_ack) begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
      RD_D: if (bus_ack) begin
        state_d = RESP_D;
        req_d   = 1'b0;
        dmem_d  = bus_rdata;
      end
      RD_I: if (bus_ack) begin
        state_d = RESP_I;
        req_d   = 1'b0;
        imem_d  = bus_rdata;
      end
      RESP_D: begin
        state_d  = IDLE;
        d_done_d = ireq;
      end
      RESP_I: begin
        state_d  = IDLE;
        d_done_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wr_ptr_q] <= dmem_addr;
      wb_data_q[wr_ptr_q] <= dmem_dataout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      imem_q   <= '0;
      dmem_q   <= '0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      imem_q   <= imem_d;
      dmem_q   <= dmem_d;
      d_done_q <= d_done_d;
    end
  end

  assign bus_req     = req_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign imem_datain = imem_q;
  assign dmem_datain = dmem_q;
  assign wb_count    = cnt_q;

endmodule

// File: tb/tb_rv_mem_bridge.sv
// Bench for rv_mem_bridge: transaction-level model of buffer and read
// queue, checked every cycle, plus directed literal scenarios.
module tb_rv_mem_bridge;
  localparam int W = 32;
  localparam int D = 4;
  localparam logic [31:0] AM = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ireq = 0, dreq = 0, memrw = 0, bus_ack = 0;
  logic [W-1:0] imem_addr = 0, dmem_addr = 0, dmem_dataout = 0;
  logic [W-1:0] bus_rdata = 0;
  logic [W-1:0] imem_datain, dmem_datain, bus_addr, bus_wdata;
  logic stall, bus_req, bus_we;
  logic [2:0] wb_count;

  always #5 clk = ~clk;

  rv_mem_bridge #(.DPWIDTH(W), .WBDEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .imem_addr(imem_addr), .imem_datain(imem_datain),
    .dreq(dreq), .memrw(memrw), .dmem_addr(dmem_addr),
    .dmem_dataout(dmem_dataout), .dmem_datain(dmem_datain),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .wb_count(wb_count)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // bus responder
  int ack_mode = 0;
  int ack_delay = 0;
  int hold = 0;
  bit rd_fixed = 0;
  logic [31:0] rd_val = 0;

  always @(posedge clk) begin
    #1;
    hold = bus_req ? hold + 1 : 0;
    case (ack_mode)
      0: bus_ack = 1'b0;
      1: bus_ack = bus_req && (hold > ack_delay);
      2: bus_ack = 1'($urandom_range(0, 1));
      default: bus_ack = 1'b1;
    endcase
    bus_rdata = rd_fixed ? rd_val : $urandom;
  end

  // reference model
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { bit is_i; logic [31:0] a; } rd_t;
  wr_t wq[$];
  rd_t rq[$];
  bit resp_now = 0;
  logic [31:0] exp_dmem = 0, exp_imem = 0;
  logic p_req = 0, p_ack = 0, p_we = 0;
  logic [31:0] p_addr = 0, p_wdata = 0;
  bit rdreq, nresp, dopush;
  wr_t pw;

  always @(negedge clk) begin
    if (!rst) begin
      wq.delete();
      rq.delete();
      resp_now = 0;
      exp_dmem = 0;
      exp_imem = 0;
      p_req = 0;
      p_ack = 0;
    end else begin
      rdreq = (dreq && !memrw) || ireq;
      nresp = 0;
      chk(int'(wb_count) == wq.size(), "wb_count", 32'(wb_count),
          32'(wq.size()));
      if (dreq && memrw)
        chk(stall == (wq.size() == D), "stall_wr", 32'(stall),
            32'(wq.size() == D));
      else if (rdreq)
        chk(stall == !resp_now, "stall_rd", 32'(stall), 32'(!resp_now));
      else
        chk(stall == 1'b0, "stall_idle", 32'(stall), 0);
      if (resp_now) begin
        chk(dmem_datain == exp_dmem, "dmem_datain", dmem_datain, exp_dmem);
        chk(imem_datain == exp_imem, "imem_datain", imem_datain, exp_imem);
      end
      if (p_req && !p_ack)
        chk(bus_req && bus_we == p_we && bus_addr == p_addr &&
            bus_wdata == p_wdata, "bus_hold", bus_addr, p_addr);
      if (p_req && p_ack)
        chk(!bus_req, "bus_gap", 32'(bus_req), 0);
      dopush = dreq && memrw && (wq.size() < D);
      pw = '{dmem_addr & AM, dmem_dataout};
      if (bus_req && bus_ack) begin
        if (bus_we) begin
          if (wq.size() == 0)
            chk(0, "spurious_wr", bus_addr, 0);
          else begin
            chk(bus_addr == wq[0].a && bus_wdata == wq[0].d, "wr_order",
                bus_addr ^ bus_wdata, wq[0].a ^ wq[0].d);
            void'(wq.pop_front());
          end
        end else begin
          chk(wq.size() == 0, "rd_gating", 32'(wq.size()), 0);
          if (rq.size() == 0)
            chk(0, "spurious_rd", bus_addr, 0);
          else begin
            chk(bus_addr == (rq[0].a & AM), "rd_addr", bus_addr,
                rq[0].a & AM);
            if (rq[0].is_i) exp_imem = bus_rdata;
            else exp_dmem = bus_rdata;
            void'(rq.pop_front());
            if (rq.size() == 0) nresp = 1;
          end
        end
      end
      if (dopush) wq.push_back(pw);
      resp_now = nresp;
      p_req = bus_req;
      p_ack = bus_ack;
      p_we = bus_we;
      p_addr = bus_addr;
      p_wdata = bus_wdata;
    end
  end

  // core-side driver
  task automatic idle();
    dreq = 0;
    ireq = 0;
    memrw = 0;
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d);
    ireq = 0;
    dreq = 1;
    memrw = 1;
    dmem_addr = a;
    dmem_dataout = d;
  endtask

  task automatic issue_read(input bit dd, input bit ii,
                            input logic [31:0] ad, input logic [31:0] ai);
    dreq = dd;
    memrw = 0;
    ireq = ii;
    dmem_addr = ad;
    imem_addr = ai;
    if (dd) rq.push_back('{1'b0, ad});
    if (ii) rq.push_back('{1'b1, ai});
  endtask

  task automatic wait_nostall(output int reqcyc);
    reqcyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_req) reqcyc++;
      if (!stall) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk(0, "stall_timeout", 32'(stall), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wb_count == 0 && !bus_req) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk(0, "drain_timeout", 32'(wb_count), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int nc;

  initial begin
    #1 rst = 0;
    #2;
    chk({bus_req, bus_we, stall} == 3'b000, "rst_ctl",
        32'({bus_req, bus_we, stall}), 0);
    chk(bus_addr == 0 && bus_wdata == 0, "rst_bus", bus_addr | bus_wdata, 0);
    chk(imem_datain == 0 && dmem_datain == 0 && wb_count == 0, "rst_data",
        imem_datain | dmem_datain | 32'(wb_count), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1;
    @(posedge clk);
    #1;

    // single posted write, ack tied high
    ack_mode = 3;
    issue_write(32'h100, 32'hDEADBEEF);
    @(negedge clk);
    chk(stall == 0, "wr_nostall", 32'(stall), 0);
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    chk(wb_count == 1, "wr_count1", 32'(wb_count), 1);
    @(negedge clk);
    chk(bus_req && bus_we, "wr_req", 32'({bus_req, bus_we}), 3);
    chk(bus_addr == 32'h100, "wr_addr", bus_addr, 32'h100);
    chk(bus_wdata == 32'hDEADBEEF, "wr_data", bus_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk(wb_count == 0, "wr_count0", 32'(wb_count), 0);
    @(posedge clk);
    #1;

    // fetch with ack delayed 3 cycles
    ack_mode = 1;
    ack_delay = 3;
    rd_fixed = 1;
    rd_val = 32'h00500093;
    issue_read(0, 1, 0, 32'h4);
    wait_nostall(nc);
    idle();
    chk(nc == 4, "fetch_req_cycles", 32'(nc), 4);
    chk(imem_datain == 32'h00500093, "fetch_data", imem_datain,
        32'h00500093);
    rd_fixed = 0;

    // five back-to-back writes with bus stalled
    ack_mode = 0;
    for (int i = 1; i <= 4; i++) begin
      issue_write(32'h1000 + 32'(i * 4), 32'hA0 + 32'(i));
      wait_nostall(nc);
    end
    issue_write(32'h1014, 32'hA5);
    @(negedge clk);
    chk(wb_count == 4, "full_count", 32'(wb_count), 4);
    chk(stall == 1, "full_stall", 32'(stall), 1);
    ack_mode = 1;
    ack_delay = 0;
    wait_nostall(nc);
    idle();
    drain();

    // store then load of the same address
    ack_mode = 2;
    issue_write(32'h200, 32'h12345678);
    wait_nostall(nc);
    issue_read(1, 0, 32'h200, 0);
    wait_nostall(nc);
    idle();

    // simultaneous load and fetch
    issue_read(1, 1, 32'h300, 32'h8);
    wait_nostall(nc);
    idle();

    // randomized traffic
    for (int k = 0; k < 150; k++) begin
      int op;
      op = $urandom_range(0, 3);
      case (op)
        0, 1: issue_write($urandom, $urandom);
        2: issue_read(1, 0, $urandom, 0);
        default: issue_read($urandom_range(0, 1) == 1, 1, $urandom,
                            $urandom);
      endcase
      wait_nostall(nc);
      idle();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    // reset in the middle of a buffered drain
    ack_mode = 0;
    for (int i = 0; i < 3; i++) begin
      issue_write(32'h4000 + 32'(i * 4), $urandom);
      wait_nostall(nc);
    end
    idle();
    repeat (3) @(posedge clk);
    #3 rst = 0;
    #1;
    chk({bus_req, bus_we, stall} == 3'b000, "arst_ctl",
        32'({bus_req, bus_we, stall}), 0);
    chk(bus_addr == 0 && bus_wdata == 0, "arst_bus",
        bus_addr | bus_wdata, 0);
    chk(imem_datain == 0 && dmem_datain == 0 && wb_count == 0, "arst_data",
        imem_datain | dmem_datain | 32'(wb_count), 0);
    ack_mode = 3;
    @(posedge clk);
    #3 rst = 1;
    repeat (6) begin
      @(negedge clk);
      chk(bus_req == 0, "post_rst_req", 32'(bus_req), 0);
      chk(wb_count == 0, "post_rst_count", 32'(wb_count), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_mem_bridge.md
Name: rv_mem_bridge

Overview:
- Memory-side neighbour of the multicycle RISC-V core. It consumes the core's instruction and data memory ports and serialises them onto one external word bus that uses a req/ack handshake.
- Data writes are posted into a small write buffer, so a store costs the core 0 stall cycles unless the buffer is full.
- Reads stall the core until the bus returns data.
- Gives the core a single memory port with a stall output.

Parameters:
DPWIDTH, 32, address/data width in bits.
WBDEPTH, 4, write-buffer entries; power of two, >=2.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
ireq  in  1  instruction fetch request; held by core until stall=0.
imem_addr  in  DPWIDTH  fetch address.
imem_datain  out  DPWIDTH  fetched instruction (registered).
dreq  in  1  data access request; held by core until stall=0.
memrw  in  1  1=write, 0=read; qualified by dreq.
dmem_addr  in  DPWIDTH  data address.
dmem_dataout  in  DPWIDTH  store data from core.
dmem_datain  out  DPWIDTH  load data to core (registered).
stall  out  1  core must hold all request inputs stable while 1.
bus_req  out  1  external transaction request (registered).
bus_we  out  1  1=write (registered).
bus_addr  out  DPWIDTH  word address; bits [1:0] forced 0 (registered).
bus_wdata  out  DPWIDTH  write data (registered).
bus_ack  in  1  transaction completes in any cycle where bus_req=1 and bus_ack=1.
bus_rdata  in  DPWIDTH  read data; valid in the ack cycle.
wb_count  out  $clog2(WBDEPTH+1)  current write-buffer occupancy.

Behaviour:
- Reset (rst=0, async): FSM to IDLE; buffer emptied and pending writes discarded; pointers 0. Every output is 0: bus_req, bus_we, bus_addr, bus_wdata, imem_datain, dmem_datain, wb_count, stall. Aborts any in-flight bus transaction with no completion; a late bus_ack is ignored.
- Addresses are word-aligned; addr[1:0] are ignored throughout.
- Write push: when dreq=1, memrw=1 and buffer not full, push {addr, data} at the edge and drive stall=0 that cycle (combinational).
  - Buffer full: stall=1. Push happens in the first cycle a slot frees; a pop frees the slot for the next cycle, with no same-cycle push-through.
- Read gating: a read (dreq&!memrw, or ireq) is issued only when the buffer is empty. This covers RAW ordering.
- Stall: stall=1 while a read is pending, until the RESP cycle for that read.
- FSM states: IDLE, WR, RD_D, RD_I, RESP_D, RESP_I.
  - IDLE, priority order:
    - buffer non-empty -> WR (load head into the bus registers, bus_req=1, bus_we=1);
    - else dreq read -> RD_D;
    - else ireq -> RD_I.
  - WR: hold bus_req, bus_addr and bus_wdata stable until ack. On ack, pop the head, bus_req=0 next cycle, go to IDLE. There is always at least 1 idle bus cycle between transactions.
  - RD_D / RD_I: bus_req=1, bus_we=0. On ack, capture bus_rdata into dmem_datain / imem_datain, bus_req=0, go to RESP_D / RESP_I.
  - RESP_x: stall=0 for exactly this cycle, and the core samples at the edge. Then go to IDLE. The data registers hold their value until the next read of the same kind.
- Simultaneous dreq read and ireq: the data read is served first and stall stays 1. The fetch is served afterwards.
- Minimum read latency is 3 cycles: request cycle (IDLE), RD with immediate ack, RESP.
- Write drain is 2 cycles per entry with immediate ack.
- wb_count = pushes - pops. A push and a pop in the same cycle leave it unchanged.
- Bus outputs are stable while bus_req=1 and bus_ack=0 (no retraction).

Test Plan:
- Reset, then dreq write, addr 0x100, data 0xDEADBEEF, bus_ack tied 1 -> stall=0 in the request cycle; wb_count 1. Next cycle bus_req=1, bus_we=1, bus_addr=0x100, bus_wdata=0xDEADBEEF; then wb_count returns to 0.
- ireq at 0x4 with bus_ack delayed 3 cycles, bus_rdata=0x00500093 -> bus_req held 4 cycles with addr 0x4; imem_datain=0x00500093; stall drops exactly one cycle after ack.
- 5 back-to-back writes with bus_ack=0 -> wb_count reaches 4; stall=1 on the 5th write. Release ack -> 5th write pushes the cycle after the first pop; bus order is 1..5.
- Write to 0x200, then immediate dreq read of 0x200 -> read waits until the buffer drains. Bus shows the write before the read; dmem_datain equals the bus_rdata returned.
- dreq read 0x300 and ireq 0x8 asserted together -> bus order 0x300 then 0x8; stall=1 until RESP_I.
- Assert rst mid-WR with 3 entries buffered -> all outputs 0 immediately; after release, a bus_ack arriving is ignored; wb_count=0; no writes reissued.
